// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I encodings for the execute stage
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit wrap-around ALU; Zero always reflects SrcA-SrcB
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero
);

    logic [XLEN-1:0] diff;

    assign diff = SrcA - SrcB;
    // Branches rely on Zero regardless of the selected operation.
    assign Zero = (diff == '0);

    always_comb begin
        ALUResult = '0;
        case (ALUControl)
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = diff;
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_XOR: ALUResult = SrcA ^ SrcB;
            ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLL: ALUResult = SrcA << SrcB[4:0];
            ALU_SRL: ALUResult = SrcA >> SrcB[4:0];
            default: ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RV32I EX stage: forwarding, ALU, branch/jump resolution, EX/MEM register
module execute_cycle
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] InstrE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);

    logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, ALUResultE;
    logic            ZeroE, taken;
    logic [2:0]      funct3;
    logic            unused_instr;

    assign funct3       = InstrE[14:12];
    assign unused_instr = &{1'b0, InstrE[31:15], InstrE[11:0]};

    // Select 11 falls through to the register-file value.
    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                            input logic [XLEN-1:0] w, input logic [XLEN-1:0] m);
        case (sel)
            FWD_W:   return w;
            FWD_M:   return m;
            default: return rf;
        endcase
    endfunction

    assign SrcAE      = fwd(ForwardAE, RD1_E, ResultW, ALUResultM);
    assign WriteDataE = fwd(ForwardBE, RD2_E, ResultW, ALUResultM);
    assign SrcBE      = ALUSrcE ? ImmExtE : WriteDataE;

    alu u_alu (
        .SrcA       (SrcAE),
        .SrcB       (SrcBE),
        .ALUControl (ALUControlE),
        .ALUResult  (ALUResultE),
        .Zero       (ZeroE)
    );

    always_comb begin
        taken = 1'b0;
        case (funct3)
            BEQ:     taken = ZeroE;
            BNE:     taken = !ZeroE;
            BLT:     taken = $signed(SrcAE) <  $signed(SrcBE);
            BGE:     taken = $signed(SrcAE) >= $signed(SrcBE);
            BLTU:    taken = SrcAE <  SrcBE;
            BGEU:    taken = SrcAE >= SrcBE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE    = JumpE | (BranchE & taken);
    assign PCTargetE = jalrE ? ((SrcAE + ImmExtE) & ~32'h1) : (PCE + ImmExtE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else begin
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule
